// File: rtl/insn_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the RV32I core.
// Define CTRL_TRAP_EN to trap illegal instructions into HALT and expose the halted port.
module insn_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] insn,
    input  logic        EQ,
    input  logic        LS,
    input  logic        LU,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_en,
    output logic        pc_en,
    output logic        pc_alu_sel,
    output logic        pc_jalr,
    output logic        reg_we,
    output logic [2:0]  state
`ifdef CTRL_TRAP_EN
    ,
    output logic        halted
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    state_t state_q, state_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_branch, is_load, is_store, is_jal, is_jalr, is_nop, is_alu;
    logic       branch_f3_ok, branch_taken, exec_illegal;
    logic       unused_insn_bits;

    assign opcode = insn[6:0];
    assign funct3 = insn[14:12];

    // Register fields are consumed by the datapath decoders, not here.
    assign unused_insn_bits = ^{insn[31:15], insn[11:7]};

    assign is_branch = (opcode == OPC_BRANCH);
    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_jal    = (opcode == OPC_JAL);
    assign is_jalr   = (opcode == OPC_JALR);
    assign is_nop    = (opcode == OPC_FENCE) || (opcode == OPC_SYSTEM);
    assign is_alu    = (opcode == OPC_LUI) || (opcode == OPC_AUIPC) ||
                       (opcode == OPC_OP)  || (opcode == OPC_OPIMM);

    always_comb begin
        branch_f3_ok = 1'b1;
        branch_taken = 1'b0;
        case (funct3)
            3'b000:  branch_taken = EQ;
            3'b001:  branch_taken = !EQ;
            3'b100:  branch_taken = LS;
            3'b101:  branch_taken = !LS;
            3'b110:  branch_taken = LU;
            3'b111:  branch_taken = !LU;
            default: branch_f3_ok = 1'b0;
        endcase
    end

    assign exec_illegal = !(is_branch || is_load || is_store || is_jal ||
                            is_jalr || is_nop || is_alu) ||
                          (is_branch && !branch_f3_ok);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Every strobe is gated off while reset is asserted, whatever the state register holds.
    always_comb begin
        state_d      = state_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_en        = 1'b0;
        pc_en        = 1'b0;
        pc_alu_sel   = 1'b0;
        pc_jalr      = 1'b0;
        reg_we       = 1'b0;
`ifdef CTRL_TRAP_EN
        halted       = 1'b0;
`endif
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_en   = 1'b1;
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: begin
                    state_d = S_EXEC;
                end
                S_EXEC: begin
                    if (exec_illegal) begin
`ifdef CTRL_TRAP_EN
                        state_d = S_HALT;
`else
                        pc_en   = 1'b1;
                        state_d = S_FETCH;
`endif
                    end else if (is_branch) begin
                        pc_en      = 1'b1;
                        pc_alu_sel = branch_taken;
                        state_d    = S_FETCH;
                    end else if (is_load || is_store) begin
                        state_d = S_MEM;
                    end else if (is_nop) begin
                        pc_en   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
                S_MEM: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = is_store;
                    if (mem_ready) begin
                        if (is_store) begin
                            pc_en   = 1'b1;
                            state_d = S_FETCH;
                        end else begin
                            state_d = S_WB;
                        end
                    end
                end
                S_WB: begin
                    reg_we     = 1'b1;
                    pc_en      = 1'b1;
                    pc_alu_sel = is_jal || is_jalr;
                    pc_jalr    = is_jalr;
                    state_d    = S_FETCH;
                end
                S_HALT: begin
`ifdef CTRL_TRAP_EN
                    halted = 1'b1;
`else
                    state_d = S_FETCH;
`endif
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_insn_sequencer.sv
// Directed self-checking bench for insn_sequencer: reset, branches, load/store, jumps, NOPs, illegal.
// Honors CTRL_TRAP_EN to select the trap or NOP expectation for illegal instructions.
module tb_insn_sequencer;

    logic        clk;
    logic        reset;
    logic [31:0] insn;
    logic        EQ, LS, LU;
    logic        mem_ready;
    logic        mem_req, mem_we, mem_addr_sel, ir_en, pc_en, pc_alu_sel, pc_jalr, reg_we;
    logic [2:0]  state;
`ifdef CTRL_TRAP_EN
    logic        halted;
`endif

    int checks = 0;
    int errors = 0;

    // Strobe vector order: {mem_req, mem_we, mem_addr_sel, ir_en, pc_en, pc_alu_sel, pc_jalr, reg_we}
    logic [7:0] strobes;
    assign strobes = {mem_req, mem_we, mem_addr_sel, ir_en, pc_en, pc_alu_sel, pc_jalr, reg_we};

    localparam logic [7:0] IDLE       = 8'b0000_0000;
    localparam logic [7:0] F_RDY      = 8'b1001_0000;
    localparam logic [7:0] F_WAIT     = 8'b1000_0000;
    localparam logic [7:0] BR_TAKEN   = 8'b0000_1100;
    localparam logic [7:0] PC_SEQ     = 8'b0000_1000;
    localparam logic [7:0] LD_MEM     = 8'b1010_0000;
    localparam logic [7:0] ST_WAIT    = 8'b1110_0000;
    localparam logic [7:0] ST_DONE    = 8'b1110_1000;
    localparam logic [7:0] WB_PLAIN   = 8'b0000_1001;
    localparam logic [7:0] WB_JAL     = 8'b0000_1101;
    localparam logic [7:0] WB_JALR    = 8'b0000_1111;

    localparam logic [31:0] I_BEQ   = 32'h00520463;
    localparam logic [31:0] I_BNE   = 32'h00521463;
    localparam logic [31:0] I_BLT   = 32'h00524463;
    localparam logic [31:0] I_BGEU  = 32'h00527463;
    localparam logic [31:0] I_BBAD  = 32'h00522463;
    localparam logic [31:0] I_LW    = 32'h0002A303;
    localparam logic [31:0] I_SW    = 32'h0062A023;
    localparam logic [31:0] I_JAL   = 32'h0000006F;
    localparam logic [31:0] I_JALR  = 32'h00008067;
    localparam logic [31:0] I_ADDI  = 32'h00100093;
    localparam logic [31:0] I_FENCE = 32'h0000000F;
    localparam logic [31:0] I_ILL   = 32'h0000007F;

    insn_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .insn         (insn),
        .EQ           (EQ),
        .LS           (LS),
        .LU           (LU),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_en        (ir_en),
        .pc_en        (pc_en),
        .pc_alu_sel   (pc_alu_sel),
        .pc_jalr      (pc_jalr),
        .reg_we       (reg_we),
        .state        (state)
`ifdef CTRL_TRAP_EN
        ,
        .halted       (halted)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One call = one clock cycle; inputs change just after the falling edge.
    task automatic applyStimulus(input logic [31:0] i, input logic eq, input logic ls,
                                 input logic lu, input logic rdy, input logic rst);
        @(negedge clk);
        reset     = rst;
        insn      = i;
        EQ        = eq;
        LS        = ls;
        LU        = lu;
        mem_ready = rdy;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkCycle(input string tag, input logic [2:0] exp_state,
                              input logic [7:0] exp_strobes);
        checkOutput({tag, ".state"}, {29'd0, state}, {29'd0, exp_state});
        checkOutput({tag, ".strobes"}, {24'd0, strobes}, {24'd0, exp_strobes});
    endtask

    task automatic fetchDecode(input string tag, input logic [31:0] i);
        applyStimulus(i, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkCycle({tag, ".F"}, 3'd0, F_RDY);
        applyStimulus(i, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkCycle({tag, ".D"}, 3'd1, IDLE);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; insn = '0; EQ = 1'b0; LS = 1'b0; LU = 1'b0; mem_ready = 1'b1;

        // Reset held two cycles: strobes must stay low
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("rst1.strobes", {24'd0, strobes}, 32'd0);
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("rst2.strobes", {24'd0, strobes}, 32'd0);
`ifdef CTRL_TRAP_EN
        checkOutput("rst2.halted", {31'd0, halted}, 32'd0);
`endif

        // Taken BEQ, including the combinational flag follow in EXEC
        fetchDecode("beq_t", I_BEQ);
        applyStimulus(I_BEQ, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        checkCycle("beq_t.E", 3'd2, BR_TAKEN);
        EQ = 1'b0; #1;
        checkCycle("beq_t.E_flagdrop", 3'd2, PC_SEQ);
        EQ = 1'b1; #1;

        // Not-taken BEQ
        fetchDecode("beq_nt", I_BEQ);
        applyStimulus(I_BEQ, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkCycle("beq_nt.E", 3'd2, PC_SEQ);

        // BNE taken on EQ=0
        fetchDecode("bne", I_BNE);
        applyStimulus(I_BNE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkCycle("bne.E", 3'd2, BR_TAKEN);

        // BLT taken on LS
        fetchDecode("blt", I_BLT);
        applyStimulus(I_BLT, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        checkCycle("blt.E", 3'd2, BR_TAKEN);

        // BGEU not taken when LU=1
        fetchDecode("bgeu", I_BGEU);
        applyStimulus(I_BGEU, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkCycle("bgeu.E", 3'd2, PC_SEQ);

        // Fetch wait states, then a load with two MEM wait cycles
        applyStimulus(I_LW, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkCycle("fwait1", 3'd0, F_WAIT);
        applyStimulus(I_LW, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkCycle("fwait2", 3'd0, F_WAIT);
        fetchDecode("lw", I_LW);
        applyStimulus(I_LW, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkCycle("lw.E", 3'd2, IDLE);
        applyStimulus(I_LW, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkCycle("lw.M_wait1", 3'd3, LD_MEM);
        applyStimulus(I_LW, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkCycle("lw.M_wait2", 3'd3, LD_MEM);
        applyStimulus(I_LW, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkCycle("lw.M_ready", 3'd3, LD_MEM);
        applyStimulus(I_LW, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkCycle("lw.W", 3'd4, WB_PLAIN);

        // Store with one MEM wait cycle
        fetchDecode("sw", I_SW);
        applyStimulus(I_SW, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkCycle("sw.E", 3'd2, IDLE);
        applyStimulus(I_SW, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkCycle("sw.M_wait", 3'd3, ST_WAIT);
        applyStimulus(I_SW, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkCycle("sw.M_ready", 3'd3, ST_DONE);

        // Jumps and a plain ALU op
        fetchDecode("jal", I_JAL);
        applyStimulus(I_JAL, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkCycle("jal.E", 3'd2, IDLE);
        applyStimulus(I_JAL, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkCycle("jal.W", 3'd4, WB_JAL);
        fetchDecode("jalr", I_JALR);
        applyStimulus(I_JALR, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(I_JALR, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkCycle("jalr.W", 3'd4, WB_JALR);
        fetchDecode("addi", I_ADDI);
        applyStimulus(I_ADDI, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(I_ADDI, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        checkCycle("addi.W", 3'd4, WB_PLAIN);

        // FENCE retires as a NOP from EXEC
        fetchDecode("fence", I_FENCE);
        applyStimulus(I_FENCE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkCycle("fence.E", 3'd2, PC_SEQ);

        // Reset during a pending load access abandons it
        fetchDecode("lw_rst", I_LW);
        applyStimulus(I_LW, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(I_LW, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkCycle("lw_rst.M_wait", 3'd3, LD_MEM);
        applyStimulus(I_LW, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("lw_rst.during.strobes", {24'd0, strobes}, 32'd0);
        applyStimulus(I_LW, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkCycle("lw_rst.after", 3'd0, F_WAIT);

        // Illegal opcode and illegal branch funct3
`ifdef CTRL_TRAP_EN
        fetchDecode("ill", I_ILL);
        applyStimulus(I_ILL, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkCycle("ill.E", 3'd2, IDLE);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(I_ILL, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            checkCycle("ill.HALT", 3'd5, IDLE);
            checkOutput("ill.halted", {31'd0, halted}, 32'd1);
        end
        applyStimulus(I_ILL, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("ill.rst.halted", {31'd0, halted}, 32'd0);
        fetchDecode("bbad", I_BBAD);
        applyStimulus(I_BBAD, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        checkCycle("bbad.E", 3'd2, IDLE);
        applyStimulus(I_BBAD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkCycle("bbad.HALT", 3'd5, IDLE);
        checkOutput("bbad.halted", {31'd0, halted}, 32'd1);
`else
        fetchDecode("ill", I_ILL);
        applyStimulus(I_ILL, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkCycle("ill.E", 3'd2, PC_SEQ);
        fetchDecode("bbad", I_BBAD);
        applyStimulus(I_BBAD, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        checkCycle("bbad.E", 3'd2, PC_SEQ);
        applyStimulus(I_BBAD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkCycle("bbad.back", 3'd0, F_RDY);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
